pc_fetch_ctrl: RTL

PC_FETCH_CTRL -- requirements
Module: pc_fetch_ctrl

---
 rtl/pc_fetch_ctrl.sv | 94 +++++++++
 1 files changed

// File: rtl/pc_fetch_ctrl.sv
// Fetch-stage PC sequencer: next-PC selection, pipeline flushes,
// halt handling and saturating fetch/redirect counters.
module pc_fetch_ctrl #(
    parameter int AddrWidth     = 16,
    parameter int JumpOffBits   = 12,
    parameter int BranchOffBits = 8,
    parameter int CountWidth    = 16,
    parameter logic [AddrWidth-1:0] ResetPC = '0
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     Stall,
    input  logic                     JumpValid,
    input  logic [AddrWidth-1:0]     JumpPC,
    input  logic [JumpOffBits-1:0]   JumpOffset,
    input  logic                     BranchTaken,
    input  logic [AddrWidth-1:0]     BranchPC,
    input  logic [BranchOffBits-1:0] BranchOffset,
    input  logic                     HaltDetect,
    output logic [AddrWidth-1:0]     PC,
    output logic                     FetchValid,
    output logic                     FlushIF,
    output logic                     FlushID,
    output logic                     Halted,
    output logic [CountWidth-1:0]    FetchCount,
    output logic [CountWidth-1:0]    RedirectCount
);

    typedef enum logic {
        StRun,
        StHalted
    } stateT;

    localparam int JumpExt   = AddrWidth - JumpOffBits;
    localparam int BranchExt = AddrWidth - BranchOffBits;

    stateT                state;
    stateT                stateNext;
    logic [AddrWidth-1:0] pcNext;
    logic [AddrWidth-1:0] jumpTarget;
    logic [AddrWidth-1:0] branchTarget;
    logic                 haltAccept;

    assign jumpTarget = JumpPC + AddrWidth'(1)
        + {{JumpExt{JumpOffset[JumpOffBits-1]}}, JumpOffset};
    assign branchTarget = BranchPC + AddrWidth'(1)
        + {{BranchExt{BranchOffset[BranchOffBits-1]}}, BranchOffset};

    assign Halted = (state == StHalted);

    // Branch (EX) outranks jump (ID), which outranks halt and stall.
    always_comb begin
        stateNext  = state;
        pcNext     = PC;
        FetchValid = 1'b0;
        FlushIF    = 1'b0;
        FlushID    = 1'b0;
        haltAccept = 1'b0;
        if (RST && state == StRun) begin
            FlushIF    = BranchTaken | JumpValid;
            FlushID    = BranchTaken;
            haltAccept = HaltDetect & ~BranchTaken & ~JumpValid;
            FetchValid = ~Stall & ~FlushIF & ~haltAccept;
            if (BranchTaken) begin
                pcNext = branchTarget;
            end else if (JumpValid) begin
                pcNext = jumpTarget;
            end else if (haltAccept) begin
                stateNext = StHalted;
            end else if (!Stall) begin
                pcNext = PC + AddrWidth'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state         <= StRun;
            PC            <= ResetPC;
            FetchCount    <= '0;
            RedirectCount <= '0;
        end else begin
            state <= stateNext;
            PC    <= pcNext;
            if (FetchValid && FetchCount != '1) begin
                FetchCount <= FetchCount + CountWidth'(1);
            end
            if (FlushIF && RedirectCount != '1) begin
                RedirectCount <= RedirectCount + CountWidth'(1);
            end
        end
    end

endmodule
